// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divider derivation used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam logic [3:0]  DECISION_TICK = 4'd8;
  localparam logic [3:0]  LAST_TICK     = 4'd15;

  function automatic int unsigned calc_div(input int unsigned clock_hz,
                                           input int unsigned baud_hz);
    return clock_hz / (baud_hz * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver (master) and the consuming core (slave).
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_framing_err;
  logic       rx_overrun;

  modport master (
    output rx_data, rx_valid, rx_framing_err, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_framing_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: registered one-cycle pulse every DIV clocks; a sync
// clear realigns the phase so the first tick lands DIV clocks after the clear.
module uart_tick_gen #(
  parameter logic [19:0] DIV = 20'd78
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [19:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == DIV - 20'd1);
      if (count == DIV - 20'd1) begin
        count <= '0;
      end else begin
        count <= count + 20'd1;
      end
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and valid/ready byte output.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 voting over ticks 6..8.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 12_000_000,
  parameter int unsigned BAUD_HZ  = 9_600,
  parameter logic [19:0] DIV      = 20'(calc_div(CLOCK_HZ, BAUD_HZ))
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            serial_rx,
  uart_receiver_if.master rx
);

  rx_state_t   state, next_state;
  logic        sync_meta, rx_sync;
  logic        tick, clear_div;
  logic [3:0]  tcnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        bit_value, decide, bit_end;
  logic        shift_en, bit_adv, complete;
  logic [7:0]  data_q;
  logic        valid_q, ferr_q, ovr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= serial_rx;
      rx_sync   <= sync_meta;
    end
  end

  uart_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (clear_div),
    .tick  (tick)
  );

  assign decide  = tick && (tcnt == DECISION_TICK);
  assign bit_end = tick && (tcnt == LAST_TICK);

`ifdef UART_RX_MAJORITY_EN
  logic samp6, samp7;

  always_ff @(posedge clock) begin
    if (reset) begin
      samp6 <= 1'b1;
      samp7 <= 1'b1;
    end else if (tick) begin
      if (tcnt == 4'd6) samp6 <= rx_sync;
      if (tcnt == 4'd7) samp7 <= rx_sync;
    end
  end

  assign bit_value = (samp6 & samp7) | (samp6 & rx_sync) | (samp7 & rx_sync);
`else
  assign bit_value = rx_sync;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= RX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (!rx_sync) next_state = RX_START;
      RX_START: begin
        if (decide && bit_value) next_state = RX_IDLE;
        else if (bit_end)        next_state = RX_DATA;
      end
      RX_DATA:  if (bit_end && bit_cnt == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (decide) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  // STOP completes at its decision tick so a start edge right behind it is caught
  always_comb begin
    clear_div = (state == RX_IDLE) && !rx_sync;
    shift_en  = (state == RX_DATA) && decide;
    bit_adv   = (state == RX_DATA) && bit_end;
    complete  = (state == RX_STOP) && decide;
  end

  always_ff @(posedge clock) begin
    if (reset || clear_div) begin
      tcnt    <= '0;
      bit_cnt <= '0;
    end else begin
      if (tick)    tcnt    <= tcnt + 4'd1;
      if (bit_adv) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)         shift_reg <= '0;
    else if (shift_en) shift_reg <= {bit_value, shift_reg[7:1]};
  end

  // A byte finishing while the previous one is still unaccepted is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (valid_q && rx.rx_ready) ovr_q <= 1'b0;
      if (complete) begin
        if (!valid_q || rx.rx_ready) begin
          data_q  <= shift_reg;
          ferr_q  <= !bit_value;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data        = data_q;
  assign rx.rx_valid       = valid_q;
  assign rx.rx_framing_err = ferr_q;
  assign rx.rx_overrun     = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV = 4 (64 clocks per bit).
module tb_uart_receiver;

  localparam int DIV = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serial_rx = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .CLOCK_HZ (64_000),
    .BAUD_HZ  (1_000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .serial_rx (serial_rx),
    .rx        (rx_if)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int         edge_cnt = 0;
  int         last_e0 = 0;
  int         rise_cnt = 0;
  int         rise_edge = -1;
  logic [7:0] cap_data = 8'h00;
  logic       cap_ferr = 1'b0;
  logic       mon_prev = 1'b0;

  always @(posedge clock) edge_cnt++;

  always @(negedge clock) begin
    if (rx_if.rx_valid === 1'b1 && mon_prev !== 1'b1) begin
      rise_cnt++;
      rise_edge = edge_cnt;
      cap_data  = rx_if.rx_data;
      cap_ferr  = rx_if.rx_framing_err;
    end
    mon_prev = rx_if.rx_valid;
  end

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input bit glitch, input int abort_at);
    int   b, off;
    logic v;
    for (int c = 0; c < 160 * DIV; c++) begin
      @(negedge clock);
      if (c == 0) last_e0 = edge_cnt + 1;
      if (c == abort_at) begin
        serial_rx = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      b   = c / (16 * DIV);
      off = c % (16 * DIV);
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else             v = stop_bit;
      if (glitch && b >= 1 && b <= 8 && off >= 8 * DIV + 2 && off <= 9 * DIV + 1)
        v = ~v;
      serial_rx = v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      serial_rx = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (rx_if.rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
    tests++; if (rx_if.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
    tests++; if (rx_if.rx_framing_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", rx_if.rx_framing_err); end
    tests++; if (rx_if.rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr got=%b exp=0", rx_if.rx_overrun); end
    reset = 1'b0;
    idle(8);
  endtask

  task automatic test_nominal;
    rx_if.rx_ready = 1'b1;
    rise_cnt = 0;
    send_frame(8'h41, 1'b1, 1'b0, -1);
    idle(16 * DIV);
    tests++; if (rise_cnt !== 1) begin fails++; $display("FAIL nominal_pulses got=%0d exp=1", rise_cnt); end
    tests++; if (rise_edge - last_e0 !== 153 * DIV + 3) begin fails++; $display("FAIL nominal_latency got=%0d exp=%0d", rise_edge - last_e0, 153 * DIV + 3); end
    tests++; if (cap_data !== 8'h41) begin fails++; $display("FAIL nominal_data got=%h exp=41", cap_data); end
    tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL nominal_ferr got=%b exp=0", cap_ferr); end
    tests++; if (rx_if.rx_valid !== 1'b0) begin fails++; $display("FAIL nominal_valid_drop got=%b exp=0", rx_if.rx_valid); end
  endtask

  task automatic test_glitch;
    rise_cnt = 0;
    @(negedge clock);
    serial_rx = 1'b0;
    repeat (4 * DIV - 1) @(negedge clock);
    serial_rx = 1'b1;
    idle(40 * DIV);
    tests++; if (rise_cnt !== 0) begin fails++; $display("FAIL glitch_no_valid got=%0d exp=0", rise_cnt); end
    send_frame(8'h96, 1'b1, 1'b0, -1);
    idle(16 * DIV);
    tests++; if (rise_cnt !== 1) begin fails++; $display("FAIL glitch_recover_pulses got=%0d exp=1", rise_cnt); end
    tests++; if (cap_data !== 8'h96) begin fails++; $display("FAIL glitch_recover_data got=%h exp=96", cap_data); end
  endtask

  task automatic test_framing;
    rise_cnt = 0;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    idle(24 * DIV);
    tests++; if (rise_cnt !== 1) begin fails++; $display("FAIL framing_pulses got=%0d exp=1", rise_cnt); end
    tests++; if (cap_data !== 8'h55) begin fails++; $display("FAIL framing_data got=%h exp=55", cap_data); end
    tests++; if (cap_ferr !== 1'b1) begin fails++; $display("FAIL framing_ferr got=%b exp=1", cap_ferr); end
  endtask

  task automatic test_overrun;
    rx_if.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0, -1);
    send_frame(8'h34, 1'b1, 1'b0, -1);
    idle(16 * DIV);
    tests++; if (rx_if.rx_valid !== 1'b1) begin fails++; $display("FAIL overrun_valid got=%b exp=1", rx_if.rx_valid); end
    tests++; if (rx_if.rx_data !== 8'h12) begin fails++; $display("FAIL overrun_data got=%h exp=12", rx_if.rx_data); end
    tests++; if (rx_if.rx_framing_err !== 1'b0) begin fails++; $display("FAIL overrun_ferr got=%b exp=0", rx_if.rx_framing_err); end
    tests++; if (rx_if.rx_overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag got=%b exp=1", rx_if.rx_overrun); end
    rx_if.rx_ready = 1'b1;
    @(negedge clock);
    rx_if.rx_ready = 1'b0;
    tests++; if (rx_if.rx_valid !== 1'b0) begin fails++; $display("FAIL overrun_accept_valid got=%b exp=0", rx_if.rx_valid); end
    tests++; if (rx_if.rx_overrun !== 1'b0) begin fails++; $display("FAIL overrun_accept_flag got=%b exp=0", rx_if.rx_overrun); end
    rx_if.rx_ready = 1'b1;
  endtask

  task automatic test_reset_midframe;
    rx_if.rx_ready = 1'b1;
    rise_cnt = 0;
    send_frame(8'hA5, 1'b1, 1'b0, 16 * 5 * DIV + 8 * DIV);
    idle(30 * DIV);
    tests++; if (rise_cnt !== 0) begin fails++; $display("FAIL midreset_partial got=%0d exp=0", rise_cnt); end
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(16 * DIV);
    tests++; if (rise_cnt !== 1) begin fails++; $display("FAIL midreset_pulses got=%0d exp=1", rise_cnt); end
    tests++; if (cap_data !== 8'h3C) begin fails++; $display("FAIL midreset_data got=%h exp=3c", cap_data); end
    tests++; if (cap_ferr !== 1'b0) begin fails++; $display("FAIL midreset_ferr got=%b exp=0", cap_ferr); end
    tests++; if (rx_if.rx_overrun !== 1'b0) begin fails++; $display("FAIL midreset_ovr got=%b exp=0", rx_if.rx_overrun); end
  endtask

  task automatic test_majority;
    logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'hC3;
`else
    exp_data = 8'h3C;
`endif
    rise_cnt = 0;
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    idle(16 * DIV);
    tests++; if (rise_cnt !== 1) begin fails++; $display("FAIL majority_pulses got=%0d exp=1", rise_cnt); end
    tests++; if (cap_data !== exp_data) begin fails++; $display("FAIL majority_data got=%h exp=%h", cap_data, exp_data); end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_majority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
